// File: rtl/urv_divide_if.sv
// Request/result bundle between the execute stage and the iterative divider.
// master drives the request and slave returns busy, done and the result.
interface urv_divide_if;
    logic        start_i;
    logic        kill_i;
    logic [31:0] d_rs1_i;
    logic [31:0] d_rs2_i;
    logic [2:0]  d_fun_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] w_rd_o;

    modport master (
        output start_i, kill_i, d_rs1_i, d_rs2_i, d_fun_i,
        input  busy_o, done_o, w_rd_o
    );

    modport slave (
        input  start_i, kill_i, d_rs1_i, d_rs2_i, d_fun_i,
        output busy_o, done_o, w_rd_o
    );
endinterface

// File: rtl/urv_divide.sv
// RV32M DIV/DIVU/REM/REMU as a restoring radix-2 divider on operand magnitudes.
// Fixed 33-cycle latency from the accepting edge to the done_o cycle.
module urv_divide (
    input  logic         clk_i,
    input  logic         rst_n_i,
    urv_divide_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [32:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic [31:0] r_rs1;
    logic        r_is_rem;
    logic        r_qsgn;
    logic        r_rsgn;
    logic        r_dz;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_rd;

    logic        w_uns;
    logic        w_accept;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [33:0] w_shift;
    logic [33:0] w_diff;
    logic [31:0] w_q_fin;
    logic [31:0] w_r_fin;

    assign w_uns    = bus.d_fun_i[0];
    assign w_accept = bus.start_i && bus.d_fun_i[2] && !bus.kill_i;
    assign w_abs1   = (!w_uns && bus.d_rs1_i[31]) ? (~bus.d_rs1_i + 32'd1) : bus.d_rs1_i;
    assign w_abs2   = (!w_uns && bus.d_rs2_i[31]) ? (~bus.d_rs2_i + 32'd1) : bus.d_rs2_i;

    // r_quo starts as the dividend magnitude; its MSB feeds the remainder
    // while quotient bits shift in at the bottom.
    assign w_shift  = {r_rem, r_quo[31]};
    assign w_diff   = w_shift - {2'b00, r_dvs};

    assign w_q_fin  = r_qsgn ? (~r_quo + 32'd1) : r_quo;
    assign w_r_fin  = r_rsgn ? (~r_rem[31:0] + 32'd1) : r_rem[31:0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= IDLE;
            r_cnt    <= 5'd0;
            r_rem    <= 33'd0;
            r_quo    <= 32'd0;
            r_dvs    <= 32'd0;
            r_rs1    <= 32'd0;
            r_is_rem <= 1'b0;
            r_qsgn   <= 1'b0;
            r_rsgn   <= 1'b0;
            r_dz     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rd     <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= CALC;
                        r_busy   <= 1'b1;
                        r_is_rem <= bus.d_fun_i[1];
                        r_quo    <= w_abs1;
                        r_dvs    <= w_abs2;
                        r_rs1    <= bus.d_rs1_i;
                        r_qsgn   <= !w_uns && (bus.d_rs1_i[31] ^ bus.d_rs2_i[31]);
                        r_rsgn   <= !w_uns && bus.d_rs1_i[31];
                        r_dz     <= (bus.d_rs2_i == 32'd0);
                        r_rem    <= 33'd0;
                        r_cnt    <= 5'd31;
                    end
                end
                CALC: begin
                    if (bus.kill_i) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (!w_diff[33]) begin
                            r_rem <= w_diff[32:0];
                            r_quo <= {r_quo[30:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[32:0];
                            r_quo <= {r_quo[30:0], 1'b0};
                        end
                        r_cnt <= r_cnt - 5'd1;
                        if (r_cnt == 5'd0) r_state <= FIX;
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (!bus.kill_i) begin
                        r_done <= 1'b1;
                        // Divide by zero bypasses the sign fix-up entirely.
                        if (r_dz) r_rd <= r_is_rem ? r_rs1 : 32'hFFFF_FFFF;
                        else      r_rd <= r_is_rem ? w_r_fin : w_q_fin;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o = r_busy;
    assign bus.done_o = r_done;
    assign bus.w_rd_o = r_rd;
endmodule

// File: tb/tb_urv_divide.sv
// Bench for urv_divide: directed vector table, multi-cycle corner sequences,
// and random operands against a signed/unsigned arithmetic reference.
module tb_urv_divide;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    urv_divide_if bus ();

    urv_divide dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fun;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            r  = f[1] ? (sa % sb) : (sa / sb);
            return 32'(r);
        end
        return f[1] ? (a % b) : (a / b);
    endfunction

    // Issue one request; lat is edges from the accepting edge to done_o, -1 on timeout.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        bus.start_i = 1'b1; bus.d_fun_i = f; bus.d_rs1_i = a; bus.d_rs2_i = b;
        @(posedge clk); #1;
        bus.start_i = 1'b0; bus.d_rs1_i = $urandom; bus.d_rs2_i = $urandom;
        lat = -1; res = 32'hDEAD_BEEF;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (bus.done_o) begin
                lat = i; res = bus.w_rd_o;
                break;
            end
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    vec_t        vecs[18];
    logic [31:0] res, exp_a, last_res;
    int          lat, ndone;

    initial begin
        vecs[0]  = '{F_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vecs[1]  = '{F_REM,  32'd7,          32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{F_REM,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
        vecs[3]  = '{F_DIVU, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF};
        vecs[4]  = '{F_REMU, 32'd100,        32'd7,         32'd2};
        vecs[5]  = '{F_DIV,  32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[6]  = '{F_DIVU, 32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[7]  = '{F_REM,  32'd5,          32'd0,         32'd5};
        vecs[8]  = '{F_REMU, 32'd5,          32'd0,         32'd5};
        vecs[9]  = '{F_REM,  32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};
        vecs[10] = '{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{F_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{F_DIV,  32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA};
        vecs[13] = '{F_REM,  32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE};
        vecs[14] = '{F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[15] = '{F_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[16] = '{F_DIVU, 32'd1000,       32'd10,        32'd100};
        vecs[17] = '{F_DIV,  32'd20,         32'hFFFF_FFFB, 32'hFFFF_FFFC};

        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.kill_i = 1'b0;
        bus.d_rs1_i = '0; bus.d_rs2_i = '0; bus.d_fun_i = '0;
        #2;
        chk("reset_busy", 32'(bus.busy_o), 32'd0);
        chk("reset_done", 32'(bus.done_o), 32'd0);
        chk("reset_rd",   bus.w_rd_o,      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Non-M funct3 must not start the divider.
        @(negedge clk);
        bus.start_i = 1'b1; bus.d_fun_i = 3'b000; bus.d_rs1_i = 32'd9; bus.d_rs2_i = 32'd3;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        chk("non_m_ignored", 32'(bus.busy_o), 32'd0);

        // Directed vectors, issued back to back (each start lands in the previous done cycle).
        foreach (vecs[i]) begin
            run_op(vecs[i].fun, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d_val", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd33);
        end
        chk("done_busy_low", 32'(bus.busy_o), 32'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(bus.done_o), 32'd0);
        last_res = vecs[17].exp;

        // Kill mid-CALC, then restart two edges later.
        @(negedge clk);
        bus.start_i = 1'b1; bus.d_fun_i = F_DIVU; bus.d_rs1_i = 32'd77; bus.d_rs2_i = 32'd7;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.kill_i = 1'b1;
        @(posedge clk); #1;
        bus.kill_i = 1'b0;
        chk("kill_busy", 32'(bus.busy_o), 32'd0);
        chk("kill_done", 32'(bus.done_o), 32'd0);
        chk("kill_rd_kept", bus.w_rd_o, last_res);
        run_op(F_REMU, 32'd100, 32'd7, res, lat);
        chk("after_kill_val", res, 32'd2);
        chk("after_kill_lat", 32'(lat), 32'd33);

        // Start while busy is ignored: first result only, no second done.
        @(negedge clk);
        bus.start_i = 1'b1; bus.d_fun_i = F_DIV; bus.d_rs1_i = 32'd1000; bus.d_rs2_i = 32'hFFFF_FFF6;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b1; bus.d_fun_i = F_REMU; bus.d_rs1_i = 32'd55; bus.d_rs2_i = 32'd4;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        lat = -1; res = 32'hDEAD_BEEF;
        for (int i = 7; i <= 60; i++) begin
            @(posedge clk); #1;
            if (bus.done_o) begin lat = i; res = bus.w_rd_o; break; end
        end
        chk("busy_start_val", res, 32'hFFFF_FF9C);
        chk("busy_start_lat", 32'(lat), 32'd33);
        ndone = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.done_o) ndone++; end
        chk("busy_start_no_2nd", 32'(ndone), 32'd0);

        // Asynchronous reset mid-CALC clears outputs immediately.
        @(negedge clk);
        bus.start_i = 1'b1; bus.d_fun_i = F_DIVU; bus.d_rs1_i = 32'd500; bus.d_rs2_i = 32'd3;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("areset_busy", 32'(bus.busy_o), 32'd0);
        chk("areset_rd",   bus.w_rd_o,      32'd0);
        chk("areset_done", 32'(bus.done_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.done_o) ndone++; end
        chk("areset_no_done", 32'(ndone), 32'd0);

        // Random operands against the arithmetic reference.
        for (int n = 0; n < 1500; n++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'b100 | 3'($urandom_range(0, 3));
            a = rnd_opnd();
            b = rnd_opnd();
            exp_a = ref_div(f, a, b);
            run_op(f, a, b, res, lat);
            if (res !== exp_a || lat != 33)
                $display("  op f=%b a=%h b=%h", f, a, b);
            chk($sformatf("rnd%0d_val", n), res, exp_a);
            chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'd33);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
